// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and decoder state type, used by both encoder and decoder.
// Functions work on zero-extended vectors, so any width up to GRAY_MAX_W is handled.
package gray_pkg;

   localparam int GRAY_MAX_W = 32;

   typedef enum logic {
      INIT,
      TRACK
   } gray_dec_state_t;

   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // True when the two codes differ in exactly one bit.
   function automatic logic hamming_is_one(input logic [GRAY_MAX_W-1:0] a,
                                           input logic [GRAY_MAX_W-1:0] b);
      logic [GRAY_MAX_W-1:0] x;
      x = a ^ b;
      return (x != '0) && ((x & (x - 1)) == '0);
   endfunction

endpackage

// File: rtl/gray_sync_filter.sv
// Two-flop synchroniser plus stability filter for an asynchronous Gray bus.
// accept is combinational and fires once per stable run, on its (STABLE_CYCLES+1)th sample.
module gray_sync_filter
   import gray_pkg::*;
#(
   parameter int WIDTH         = 4,
   parameter int STABLE_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] gray_in,
   output logic [WIDTH-1:0] code,
   output logic             accept
);

   localparam int               CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;
   logic [WIDTH-1:0] r_cand;
   logic [CNT_W-1:0] r_cnt;
   logic             r_lock;
   logic             w_same;

   assign w_same = (r_s2 == r_cand);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_cand <= '0;
         r_cnt  <= '0;
         r_lock <= 1'b0;
      end else begin
         r_s1 <= gray_in;
         r_s2 <= r_s1;
         if (!w_same) begin
            r_cand <= r_s2;
            r_cnt  <= '0;
            r_lock <= 1'b0;
         end else if (r_cnt < CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end else if (!r_lock) begin
            r_lock <= 1'b1;
         end
      end
   end

   assign code   = r_cand;
   assign accept = w_same && (r_cnt == CNT_MAX) && !r_lock;

endmodule

// File: rtl/gray_bin_decoder.sv
// Gray-to-binary decoder: filtered accepts are decoded, step-checked and reported
// with a direction bit; multi-bit jumps raise err_pulse and sticky step_err.
//   state | meaning
//   INIT  | no code accepted yet since reset; next accept is loaded unchecked
//   TRACK | bin_out holds the last accepted code; accepts are step-checked
module gray_bin_decoder
   import gray_pkg::*;
#(
   parameter int WIDTH         = 4,
   parameter int STABLE_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             clr_err,
   output logic [WIDTH-1:0] bin_out,
   output logic             bin_valid,
   output logic             dir,
   output logic             err_pulse,
   output logic             step_err
);

   gray_dec_state_t  r_state;
   gray_dec_state_t  w_state_nxt;
   logic [WIDTH-1:0] r_bin_out;
   logic             r_bin_valid;
   logic             r_dir;
   logic             r_err_pulse;
   logic             r_step_err;

   logic [WIDTH-1:0] w_code;
   logic             w_accept;
   logic [WIDTH-1:0] w_new_bin;
   logic [WIDTH-1:0] w_old_gray;
   logic             w_load;
   logic             w_err;
   logic             w_dir;

   gray_sync_filter #(
      .WIDTH         (WIDTH),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_filter (
      .clk     (clk),
      .rst_n   (rst_n),
      .gray_in (gray_in),
      .code    (w_code),
      .accept  (w_accept)
   );

   assign w_new_bin  = WIDTH'(gray2bin(GRAY_MAX_W'(w_code)));
   assign w_old_gray = WIDTH'(bin2gray(GRAY_MAX_W'(r_bin_out)));

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_err       = 1'b0;
      w_dir       = 1'b0;
      case (r_state)
         INIT: begin
            if (w_accept) begin
               w_load      = 1'b1;
               w_state_nxt = TRACK;
            end
         end
         TRACK: begin
            if (w_accept && (w_code != w_old_gray)) begin
               w_load = 1'b1;
               if (hamming_is_one(GRAY_MAX_W'(w_code), GRAY_MAX_W'(w_old_gray))) begin
                  w_dir = (w_new_bin == WIDTH'(r_bin_out + WIDTH'(1)));
               end else begin
                  w_err = 1'b1;
               end
            end
         end
         default: w_state_nxt = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= INIT;
         r_bin_out   <= '0;
         r_bin_valid <= 1'b0;
         r_dir       <= 1'b0;
         r_err_pulse <= 1'b0;
         r_step_err  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_bin_valid <= w_load;
         r_err_pulse <= w_err;
         if (w_load) begin
            r_bin_out <= w_new_bin;
            r_dir     <= w_dir;
         end
         // A new error on the same edge as clr_err keeps the flag set.
         r_step_err <= w_err | (r_step_err & ~clr_err);
      end
   end

   assign bin_out   = r_bin_out;
   assign bin_valid = r_bin_valid;
   assign dir       = r_dir;
   assign err_pulse = r_err_pulse;
   assign step_err  = r_step_err;

endmodule

// File: tb/tb_gray_bin_decoder.sv
// Bench for gray_bin_decoder: directed scenarios then random holds, every cycle
// compared against a run-length / Hamming-distance reference model.
module tb_gray_bin_decoder;

   localparam int W = 4;
   localparam int S = 3;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] gray_in;
   logic         clr_err;
   logic [W-1:0] bin_out;
   logic         bin_valid;
   logic         dir;
   logic         err_pulse;
   logic         step_err;

   gray_bin_decoder #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .gray_in   (gray_in),
      .clr_err   (clr_err),
      .bin_out   (bin_out),
      .bin_valid (bin_valid),
      .dir       (dir),
      .err_pulse (err_pulse),
      .step_err  (step_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int m1, m2, run_val, run_len, e_bin;
   bit has_prev, e_valid, e_dir, e_errp, e_sterr;

   // observations captured for directed checks
   int valid_seen;
   int last_dir;
   int err_step_flag;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int gray_to_bin(input int g);
      for (int b = 0; b < (1 << W); b++)
         if ((b ^ (b >> 1)) == g) return b;
      return -1;
   endfunction

   function automatic int bin_to_gray(input int b);
      return b ^ (b >> 1);
   endfunction

   task automatic model_reset();
      m1 = 0; m2 = 0; run_val = 0; run_len = 1;
      has_prev = 0; e_bin = 0; e_valid = 0; e_dir = 0; e_errp = 0; e_sterr = 0;
   endtask

   task automatic model_edge(input int g, input bit clr);
      int x, nb, d;
      bit nerr;
      x  = m2;
      m2 = m1;
      m1 = g;
      if (x == run_val) run_len++;
      else begin
         run_val = x;
         run_len = 1;
      end
      e_valid = 0;
      e_errp  = 0;
      nerr    = 0;
      if (run_len == S + 1) begin
         nb = gray_to_bin(x);
         if (!has_prev) begin
            has_prev = 1; e_valid = 1; e_bin = nb; e_dir = 0;
         end else begin
            d = $countones(x ^ bin_to_gray(e_bin));
            if (d == 1) begin
               e_valid = 1;
               e_dir   = (nb == ((e_bin + 1) % (1 << W)));
               e_bin   = nb;
            end else if (d > 1) begin
               e_valid = 1; e_errp = 1; e_dir = 0; e_bin = nb; nerr = 1;
            end
         end
      end
      if (nerr) e_sterr = 1;
      else if (clr) e_sterr = 0;
   endtask

   // Called at a negedge: drive inputs, clock once, compare, return at next negedge.
   task automatic step(input int g, input bit clr);
      gray_in = W'(g);
      clr_err = clr;
      @(posedge clk);
      model_edge(g, clr);
      #1;
      check("bin_out",   32'(bin_out),   32'(e_bin));
      check("bin_valid", 32'(bin_valid), 32'(e_valid));
      check("err_pulse", 32'(err_pulse), 32'(e_errp));
      check("step_err",  32'(step_err),  32'(e_sterr));
      if (e_valid) check("dir", 32'(dir), 32'(e_dir));
      if (bin_valid === 1'b1) begin
         valid_seen++;
         last_dir = int'(dir);
      end
      if (err_pulse === 1'b1) err_step_flag = int'(step_err);
      @(negedge clk);
   endtask

   task automatic hold(input int g, input int n);
      for (int k = 0; k < n; k++) step(g, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_bin_out"},   32'(bin_out),   32'd0);
      check({tag, "_bin_valid"}, 32'(bin_valid), 32'd0);
      check({tag, "_dir"},       32'(dir),       32'd0);
      check({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
      check({tag, "_step_err"},  32'(step_err),  32'd0);
   endtask

   initial begin
      rst_n   = 1'b0;
      gray_in = 4'b0111;
      clr_err = 1'b0;
      valid_seen = 0; last_dir = -1; err_step_flag = -1;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // first code: bin 5 reported once, at the sixth edge after release
      for (int k = 0; k < 5; k++) step(4'b0111, 1'b0);
      check("first_not_early", 32'(valid_seen), 32'd0);
      step(4'b0111, 1'b0);
      check("first_valid_edge5", 32'(bin_valid), 32'd1);
      hold(4'b0111, 4);
      check("first_bin", 32'(bin_out), 32'd5);
      check("first_pulses", 32'(valid_seen), 32'd1);

      // up then down single steps
      hold(4'b0101, 10);
      check("up_bin", 32'(bin_out), 32'd6);
      check("up_dir", 32'(last_dir), 32'd1);
      hold(4'b0111, 10);
      check("down_bin", 32'(bin_out), 32'd5);
      check("down_dir", 32'(last_dir), 32'd0);
      check("down_no_err", 32'(step_err), 32'd0);

      // walk up to 15, then wrap both ways
      for (int b = 6; b <= 15; b++) hold(bin_to_gray(b), 6);
      check("walk_bin", 32'(bin_out), 32'd15);
      hold(4'b0000, 10);
      check("wrap_up_bin", 32'(bin_out), 32'd0);
      check("wrap_up_dir", 32'(last_dir), 32'd1);
      hold(4'b1000, 10);
      check("wrap_dn_bin", 32'(bin_out), 32'd15);
      check("wrap_dn_dir", 32'(last_dir), 32'd0);
      check("wrap_no_err", 32'(step_err), 32'd0);
      for (int b = 0; b <= 6; b++) hold(bin_to_gray(b), 6);

      // glitch shorter than the filter window
      valid_seen = 0;
      hold(4'b0100, 2);
      hold(4'b0101, 10);
      check("glitch_no_valid", 32'(valid_seen), 32'd0);
      check("glitch_bin", 32'(bin_out), 32'd6);

      // multi-bit jump, clear, then error coinciding with clear
      hold(4'b0010, 10);
      check("err_bin", 32'(bin_out), 32'd3);
      check("err_flag", 32'(step_err), 32'd1);
      step(4'b0010, 1'b1);
      check("err_cleared", 32'(step_err), 32'd0);
      err_step_flag = -1;
      for (int k = 0; k < 6; k++) step(4'b0101, 1'b1);
      check("set_wins", 32'(err_step_flag), 32'd1);
      hold(4'b0101, 4);

      // reset in the middle of filtering a new code
      for (int k = 0; k < 3; k++) step(4'b0110, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      valid_seen = 0;
      hold(4'b0110, 10);
      check("postreset_bin", 32'(bin_out), 32'd4);
      check("postreset_valid", 32'(valid_seen), 32'd1);
      check("postreset_no_err", 32'(step_err), 32'd0);

      // random holds with occasional clears
      for (int seg = 0; seg < 60; seg++) begin
         int g, n;
         g = int'($urandom_range(0, (1 << W) - 1));
         n = int'($urandom_range(1, 8));
         for (int k = 0; k < n; k++) step(g, ($urandom_range(0, 7) == 0));
      end

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule

// File: doc/gray_bin_decoder.md
# gray_bin_decoder

Sequential Gray-to-binary decoder, the receiving side of our binary-to-Gray encoder. It samples a Gray-coded bus that is asynchronous to `clk`, such as an absolute position encoder or a counter from another block. It synchronises and debounces that bus, converts accepted codes to binary, and reports each legal single-step change with a direction bit. Multi-bit jumps are flagged as step errors.

## Interface
- `WIDTH`, default 4: code width in bits; ≥2.
- `STABLE_CYCLES`, default 3: consecutive identical synchronised samples needed before a code is accepted; ≥1.
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `gray_in`  in  WIDTH  — Gray code, asynchronous to `clk`; bit WIDTH-1 is MSB.
- `clr_err`  in  1  — synchronous clear of `step_err`.
- `bin_out`  out  WIDTH  — binary value of last accepted code.
- `bin_valid`  out  1  — one-cycle pulse when `bin_out` updates.
- `dir`  out  1  — valid with `bin_valid`: 1 means new = old+1 mod 2^WIDTH, else 0.
- `err_pulse`  out  1  — one-cycle pulse when accepted code differs from previous in >1 bit.
- `step_err`  out  1  — sticky error flag.

## Operation
- Decode: `b[WIDTH-1]=g[WIDTH-1]`; `b[i]=b[i+1]^g[i]` for i<WIDTH-1.
- Sync: two-flop synchroniser on `gray_in` (`s1`, `s2`).
- Filter: candidate register `cand` and counter `cnt`, saturating at `STABLE_CYCLES-1`.
  - `s2≠cand`: `cand<=s2`, `cnt<=0`, accept-lock cleared.
  - `s2==cand` and `cnt<STABLE_CYCLES-1`: `cnt++`.
  - `s2==cand` and `cnt==STABLE_CYCLES-1` and not locked: accept; lock set.
  - The lock stops repeated accepts of the same candidate.
- FSM states `INIT`, `TRACK`.
  - `INIT`, first accept: load `bin_out`, pulse `bin_valid`, `dir=0`, no step check, go to `TRACK`.
  - `TRACK`, accept with cand == last accepted code: no output activity.
  - `TRACK`, Hamming distance 1: load `bin_out`, pulse `bin_valid`, set `dir`.
  - `TRACK`, Hamming distance >1: load `bin_out`, pulse `bin_valid` and `err_pulse`, set `step_err`, `dir=0`. Decoder resyncs to the new value.
- Wrap-around: `bin_out` WIDTH-1s → 0 is a legal up step (`dir=1`); 0 → all-ones is a legal down step.
- `clr_err` clears `step_err` at next edge. If a new error occurs on the same edge, set wins.

## Timing
- Reset (async assert, sync release): `bin_out=0`, `bin_valid=0`, `dir=0`, `err_pulse=0`, `step_err=0`, `s1=s2=cand=0`, `cnt=0`, lock clear, state `INIT`.
- Latency: with `gray_in` stable from before edge 0, outputs update at edge `STABLE_CYCLES+2` (edge 5 for default).
- Glitch rejection: any `gray_in` value held for fewer than `STABLE_CYCLES+1` synchronised samples is never accepted.
- Pulses `bin_valid` and `err_pulse` are exactly one cycle wide. Back-to-back accepts are spaced at least `STABLE_CYCLES+1` cycles apart.
- Reset mid-filter: all progress discarded; the first accept after release is treated as `INIT` (no error check).
- All outputs are registered; there is no combinational path from `gray_in`.

## Structure
- `gray_pkg`, shared with the encoder:
  - state enum `gray_dec_state_t` {`INIT`, `TRACK`};
  - functions `gray2bin` and `bin2gray`, parameterised by width;
  - Hamming-distance-is-one helper.
- Sub-module `gray_sync_filter`: synchroniser plus stability filter. Outputs `code` and a one-cycle `accept` strobe.
- Top level holds the FSM, decode, step check and error logic.

## Test plan
WIDTH=4, STABLE_CYCLES=3.
- **Reset/first code:** release reset with `gray_in=0111`; hold. Expect `bin_out=5` and one `bin_valid` pulse at edge 5, `dir=0`, no error.
- **Up/down steps:** `0111`→`0101`, held 10 cycles. Expect `bin_out=6`, `dir=1`. Then `0101`→`0111`: expect `bin_out=5`, `dir=0`, `step_err=0`.
- **Wrap:** from `1000` (15) to `0000`. Expect `bin_out=0`, `dir=1`. From `0000` to `1000`: expect `bin_out=15`, `dir=0`.
- **Glitch:** from stable `0101`, drive `0100` for 2 cycles, then back. Expect no `bin_valid` and `bin_out` stays 6.
- **Step error:** `0101`→`0010`. Expect `bin_out=3`, `bin_valid` and `err_pulse` on the same cycle, `step_err=1`. Assert `clr_err` one cycle: `step_err=0` next edge. Repeat with `clr_err` coinciding with a new error: `step_err` stays 1.
- **Reset mid-filter:** change code, assert `rst_n=0` at edge 3. Expect all outputs 0 immediately. After release, the first accepted code is reported without error.
